spi_frame_regbank: RTL and testbench

// - SPI-clock-domain command/register stage paired with the SPI slave; consumes raw MOSI bits on each capture edge.
// - Frames the bits into a command byte followed by data bytes, and holds a byte register bank.
// - Supports burst write and burst read with address auto-increment.
// - Supplies the next MISO bit to the slave's output/tri-state stage. No FPGA-clock dependency.

---
 rtl/spi_frame_regbank.sv | 224 ++++++++++++++++++++++
 tb/tb_spi_frame_regbank.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_regbank.sv
// spi_frame_regbank
//   Command/register stage in the SPI clock domain. It frames the raw MOSI bits
//   into a command byte followed by data bytes, holds a byte register bank, and
//   supports burst write and burst read with address auto-increment. It also
//   produces the next MISO bit for the slave's output stage.
//
//   A command byte is {RnW, addr[6:0]}. rd_val(a) returns reg[a] when
//   a < NUM_REGS, ID_VALUE when a == 7'h7F, and 8'h00 otherwise.
//
// Ports
//   i_Rst_L      async active-low reset; clears the bank and the frame state
//   w_SPI_Clk    capture-edge SPI clock (polarity/phase already applied)
//   i_SPI_CS_n   chip select; high = async frame reset, the bank is untouched
//   i_SPI_MOSI   serial data in, MSb first
//   o_MISO_Bit   bit to drive for the next capture edge
//   o_Wr_DV      high for one w_SPI_Clk period after a register write
//   o_Wr_Addr    address of the last write
//   o_Wr_Data    data of the last write
//   o_Regs       flat bank; reg k at [8k+7:8k]
//
// FSM states
//   state  | meaning
//   ST_CMD | collecting the command byte
//   ST_WR  | each full data byte writes reg[addr], then addr increments
//   ST_RD  | shifting rd_val(addr) out on MISO; MOSI is ignored
module spi_frame_regbank #(
  parameter int          NUM_REGS = 16,
  parameter logic [7:0]  ID_VALUE = 8'hA5
) (
  input  logic                  i_Rst_L,
  input  logic                  w_SPI_Clk,
  input  logic                  i_SPI_CS_n,
  input  logic                  i_SPI_MOSI,
  output logic                  o_MISO_Bit,
  output logic                  o_Wr_DV,
  output logic [6:0]            o_Wr_Addr,
  output logic [7:0]            o_Wr_Data,
  output logic [8*NUM_REGS-1:0] o_Regs
);

  localparam logic [7:0] NUM_REGS_W = 8'(NUM_REGS);
  localparam logic [6:0] ID_ADDR    = 7'h7F;

  typedef enum logic [1:0] {
    ST_CMD = 2'd0,
    ST_WR  = 2'd1,
    ST_RD  = 2'd2
  } state_t;

  state_t      state_q,    state_d;
  logic [2:0]  bit_cnt_q,  bit_cnt_d;
  logic [6:0]  rx_shift_q, rx_shift_d;
  // Holds the bits of the current read byte that are still to be shifted out;
  // bit 7 goes straight into the MISO flop when the byte is loaded.
  logic [6:0]  tx_shift_q, tx_shift_d;
  logic [6:0]  addr_q,     addr_d;
  logic        miso_q,     miso_d;
  logic        wr_dv_q,    wr_dv_d;

  logic [7:0]  regs_q [NUM_REGS];
  logic [7:0]  regs_d [NUM_REGS];
  logic [6:0]  wr_addr_q,  wr_addr_d;
  logic [7:0]  wr_data_q,  wr_data_d;

  logic [7:0]  rx_byte;
  logic        byte_done;
  logic        wr_fire;
  logic [6:0]  addr_nxt;
  logic [7:0]  rd_cmd_val;
  logic [7:0]  rd_nxt_val;

  function automatic logic in_range(input logic [6:0] a);
    return {1'b0, a} < NUM_REGS_W;
  endfunction

  // Addresses inside the bank wrap; anything outside stays put so repeated
  // reads keep returning the same value.
  function automatic logic [6:0] addr_inc(input logic [6:0] a);
    if (!in_range(a)) begin
      return a;
    end
    if ({1'b0, a} == (NUM_REGS_W - 8'd1)) begin
      return 7'd0;
    end
    return a + 7'd1;
  endfunction

  function automatic logic [7:0] rd_val(input logic [6:0] a);
    logic [7:0] v;
    v = (a == ID_ADDR) ? ID_VALUE : 8'h00;
    // A bank register wins over the ID value when the bank reaches 7'h7F.
    for (int k = 0; k < NUM_REGS; k++) begin
      if (a == 7'(k)) begin
        v = regs_q[k];
      end
    end
    return v;
  endfunction

  assign rx_byte    = {rx_shift_q, i_SPI_MOSI};
  assign byte_done  = (bit_cnt_q == 3'd7);
  assign addr_nxt   = addr_inc(addr_q);
  assign rd_cmd_val = rd_val(rx_byte[6:0]);
  assign rd_nxt_val = rd_val(addr_nxt);

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q + 3'd1;
    rx_shift_d = rx_byte[6:0];
    tx_shift_d = tx_shift_q;
    addr_d     = addr_q;
    miso_d     = miso_q;
    wr_dv_d    = 1'b0;
    wr_fire    = 1'b0;

    case (state_q)
      ST_CMD: begin
        if (byte_done) begin
          addr_d = rx_byte[6:0];
          if (rx_byte[7]) begin
            // Load the first read byte on the command edge so bit 7 is
            // already on MISO for capture edge 9.
            state_d    = ST_RD;
            tx_shift_d = rd_cmd_val[6:0];
            miso_d     = rd_cmd_val[7];
          end else begin
            state_d = ST_WR;
          end
        end
      end
      ST_WR: begin
        if (byte_done) begin
          wr_fire = in_range(addr_q);
          wr_dv_d = in_range(addr_q);
          addr_d  = addr_nxt;
        end
      end
      ST_RD: begin
        if (byte_done) begin
          addr_d     = addr_nxt;
          tx_shift_d = rd_nxt_val[6:0];
          miso_d     = rd_nxt_val[7];
        end else begin
          tx_shift_d = {tx_shift_q[5:0], 1'b0};
          miso_d     = tx_shift_q[6];
        end
      end
      default: begin
        state_d = ST_CMD;
      end
    endcase
  end

  // Bank and last-write info only see the global reset; CS leaves them alone.
  // wr_fire is only ever set in ST_WR, which CS high forces out of.
  always_comb begin
    regs_d    = regs_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (wr_fire) begin
      wr_addr_d = addr_q;
      wr_data_d = rx_byte;
      for (int k = 0; k < NUM_REGS; k++) begin
        if (addr_q == 7'(k)) begin
          regs_d[k] = rx_byte;
        end
      end
    end
  end

  always_ff @(posedge w_SPI_Clk or negedge i_Rst_L or posedge i_SPI_CS_n) begin
    if (!i_Rst_L) begin
      state_q    <= ST_CMD;
      bit_cnt_q  <= 3'd0;
      rx_shift_q <= 7'd0;
      tx_shift_q <= 7'd0;
      addr_q     <= 7'd0;
      miso_q     <= 1'b0;
      wr_dv_q    <= 1'b0;
    end else if (i_SPI_CS_n) begin
      state_q    <= ST_CMD;
      bit_cnt_q  <= 3'd0;
      rx_shift_q <= 7'd0;
      tx_shift_q <= 7'd0;
      addr_q     <= 7'd0;
      miso_q     <= 1'b0;
      wr_dv_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      addr_q     <= addr_d;
      miso_q     <= miso_d;
      wr_dv_q    <= wr_dv_d;
    end
  end

  always_ff @(posedge w_SPI_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= 8'h00;
      end
      wr_addr_q <= 7'd0;
      wr_data_q <= 8'h00;
    end else begin
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= regs_d[k];
      end
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign o_Regs[8*g +: 8] = regs_q[g];
  end

  assign o_MISO_Bit = miso_q;
  assign o_Wr_DV    = wr_dv_q;
  assign o_Wr_Addr  = wr_addr_q;
  assign o_Wr_Data  = wr_data_q;

endmodule

// File: tb/tb_spi_frame_regbank.sv
// Bench for spi_frame_regbank (NUM_REGS=16). Expected writes and read bytes
// are queued when stimulus is driven and compared when the DUT produces them.
module tb_spi_frame_regbank;

  logic         clk;
  logic         rst_l;
  logic         cs_n;
  logic         mosi;
  logic         miso;
  logic         wr_dv;
  logic [6:0]   wr_addr;
  logic [7:0]   wr_data;
  logic [127:0] regs;

  int n_checks = 0;
  int n_errors = 0;
  int frame_edge = 0;

  typedef struct {
    int         edge_n;
    logic [6:0] addr;
    logic [7:0] data;
  } wr_exp_t;

  wr_exp_t    wr_q [$];
  logic [7:0] rd_q [$];
  logic [7:0] mdl [16];

  spi_frame_regbank #(
    .NUM_REGS (16),
    .ID_VALUE (8'hA5)
  ) dut (
    .i_Rst_L    (rst_l),
    .w_SPI_Clk  (clk),
    .i_SPI_CS_n (cs_n),
    .i_SPI_MOSI (mosi),
    .o_MISO_Bit (miso),
    .o_Wr_DV    (wr_dv),
    .o_Wr_Addr  (wr_addr),
    .o_Wr_Data  (wr_data),
    .o_Regs     (regs)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] mdl_rd(input logic [6:0] a);
    if (a < 7'd16) return mdl[a[3:0]];
    if (a == 7'h7F) return 8'hA5;
    return 8'h00;
  endfunction

  function automatic logic [6:0] mdl_inc(input logic [6:0] a);
    if (a >= 7'd16) return a;
    return (a == 7'd15) ? 7'd0 : a + 7'd1;
  endfunction

  // Write monitor: every o_Wr_DV pulse must match the oldest expected write,
  // including the frame edge it follows.
  always @(posedge clk) begin
    wr_exp_t e;
    #1;
    if (wr_dv) begin
      if (wr_q.size() == 0) begin
        check_val("wr_dv_spurious", {25'd0, wr_addr}, 32'hFFFF_FFFF);
      end else begin
        e = wr_q.pop_front();
        check_val("wr_edge", frame_edge, e.edge_n);
        check_val("wr_addr", {25'd0, wr_addr}, {25'd0, e.addr});
        check_val("wr_data", {24'd0, wr_data}, {24'd0, e.data});
      end
    end
  end

  // Entered and left at a falling edge: MISO is sampled and MOSI driven there,
  // for the following capture edge.
  task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      rx[7-i] = miso;
      mosi = tx[7-i];
      @(posedge clk);
      frame_edge++;
      @(negedge clk);
    end
  endtask

  task automatic frame_start();
    cs_n = 1'b0;
    frame_edge = 0;
  endtask

  task automatic frame_end();
    cs_n = 1'b1;
    #1;
    check_val("dv_after_cs", {31'd0, wr_dv}, 32'd0);
    check_val("miso_after_cs", {31'd0, miso}, 32'd0);
    @(negedge clk);
  endtask

  task automatic bank_check(input string tag);
    for (int k = 0; k < 16; k++) begin
      check_val($sformatf("%s_reg%0d", tag, k), {24'd0, regs[8*k +: 8]}, {24'd0, mdl[k]});
    end
  endtask

  task automatic wr_frame(input logic [6:0] a, input int n, input logic [7:0] d [4]);
    logic [7:0] rx;
    logic [6:0] wa;
    wr_exp_t    e;
    wa = a;
    frame_start();
    xfer({1'b0, a}, 8, rx);
    for (int i = 0; i < n; i++) begin
      if (wa < 7'd16) begin
        e.edge_n = frame_edge + 8;
        e.addr   = wa;
        e.data   = d[i];
        wr_q.push_back(e);
        mdl[wa[3:0]] = d[i];
      end
      xfer(d[i], 8, rx);
      wa = mdl_inc(wa);
    end
    frame_end();
  endtask

  task automatic rd_frame(input logic [6:0] a, input int n);
    logic [7:0] rx;
    logic [7:0] exp;
    logic [6:0] ra;
    ra = a;
    frame_start();
    xfer({1'b1, a}, 8, rx);
    for (int i = 0; i < n; i++) begin
      rd_q.push_back(mdl_rd(ra));
      xfer(8'($urandom), 8, rx);
      exp = rd_q.pop_front();
      check_val($sformatf("rd_byte_a%0h_%0d", a, i), {24'd0, rx}, {24'd0, exp});
      ra = mdl_inc(ra);
    end
    frame_end();
  endtask

  initial begin
    logic [7:0] rx;
    rst_l = 1'b0;
    cs_n  = 1'b1;
    mosi  = 1'b0;
    for (int k = 0; k < 16; k++) mdl[k] = 8'h00;

    // Power-on reset state
    repeat (3) @(negedge clk);
    bank_check("por");
    check_val("por_dv", {31'd0, wr_dv}, 32'd0);
    check_val("por_addr", {25'd0, wr_addr}, 32'd0);
    check_val("por_data", {24'd0, wr_data}, 32'd0);
    check_val("por_miso", {31'd0, miso}, 32'd0);
    rst_l = 1'b1;
    @(negedge clk);

    // Reset mid-write frame
    wr_frame(7'h01, 1, '{8'h44, 8'h00, 8'h00, 8'h00});
    bank_check("pre_rst");
    frame_start();
    xfer(8'h01, 8, rx);
    xfer(8'hFF, 3, rx);
    rst_l = 1'b0;
    #1;
    for (int k = 0; k < 16; k++) mdl[k] = 8'h00;
    bank_check("mid_rst");
    check_val("rst_dv", {31'd0, wr_dv}, 32'd0);
    check_val("rst_addr", {25'd0, wr_addr}, 32'd0);
    check_val("rst_data", {24'd0, wr_data}, 32'd0);
    check_val("rst_miso", {31'd0, miso}, 32'd0);
    cs_n = 1'b1;
    @(negedge clk);
    rst_l = 1'b1;
    @(negedge clk);
    rd_frame(7'h05, 1);
    rd_frame(7'h01, 1);

    // Burst write
    wr_frame(7'h02, 3, '{8'h11, 8'h22, 8'h33, 8'h00});
    bank_check("burst_wr");

    // Burst write and read across the 15 -> 0 wrap
    wr_frame(7'h0F, 2, '{8'hC3, 8'h5A, 8'h00, 8'h00});
    rd_frame(7'h0F, 2);
    bank_check("wrap");

    // ID and out-of-range
    rd_frame(7'h7F, 2);
    rd_frame(7'h10, 2);
    wr_frame(7'h20, 1, '{8'h77, 8'h00, 8'h00, 8'h00});
    wr_frame(7'h7F, 2, '{8'h12, 8'h34, 8'h00, 8'h00});
    bank_check("oor_wr");

    // Partial byte discarded at CS rise
    wr_frame(7'h01, 1, '{8'h3C, 8'h00, 8'h00, 8'h00});
    frame_start();
    xfer(8'h01, 8, rx);
    xfer(8'hFF, 5, rx);
    frame_end();
    bank_check("partial");
    rd_frame(7'h01, 1);

    // CS abort during a read of reg4 (0x33), then a normal write/read
    frame_start();
    xfer(8'h84, 8, rx);
    xfer(8'h00, 3, rx);
    check_val("abort_bits", {29'd0, rx[7:5]}, 32'd1);
    check_val("abort_miso_pre", {31'd0, miso}, 32'd1);
    frame_end();
    wr_frame(7'h03, 1, '{8'h9C, 8'h00, 8'h00, 8'h00});
    rd_frame(7'h03, 1);
    bank_check("final");

    repeat (2) @(negedge clk);
    check_val("wr_q_empty", wr_q.size(), 32'd0);
    check_val("rd_q_empty", rd_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
